// File: rtl/direct_ctrl_multi.sv
// -----------------------------------------------------------------------------
// direct_ctrl_multi
// Per-player tank direction controller. Every raw button bit is synchronised
// through two flops and then debounced. Each player's four stable bits are
// resolved into a 3-bit heading plus a moving flag. The heading holds while
// the player is idle.
//
// Ports
//   clk_100mhz  in   1               system clock
//   rst         in   1               async reset, active-high
//   btn         in   4*NUM_PLAYERS   raw buttons; per player bit0 L, bit1 R, bit2 U, bit3 D
//   direct      out  3*NUM_PLAYERS   heading per player; L 000, R 001, U 010, D 011
//   moving      out  NUM_PLAYERS     player commanded to move
//   turn        out  NUM_PLAYERS     one-cycle pulse on heading change
//                                    (present only when DIRECT_TURN_PULSE_EN is defined)
//
// Optional feature macro: DIRECT_TURN_PULSE_EN
// -----------------------------------------------------------------------------
module direct_ctrl_multi #(
   parameter int unsigned NUM_PLAYERS     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned MULTI_MODE      = 0,
   parameter logic [2:0]  RESET_DIR       = 3'b010
) (
   input  logic                       clk_100mhz,
   input  logic                       rst,
   input  logic [4*NUM_PLAYERS-1:0]   btn,
   output logic [3*NUM_PLAYERS-1:0]   direct,
   output logic [NUM_PLAYERS-1:0]     moving
`ifdef DIRECT_TURN_PULSE_EN
   ,
   output logic [NUM_PLAYERS-1:0]     turn
`endif
);

   localparam int unsigned NB = 4 * NUM_PLAYERS;
   localparam int unsigned ND = 3 * NUM_PLAYERS;
   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

   logic [NB-1:0]          sync1_q, sync2_q;
   logic [NB-1:0]          stable_q, stable_d;
   logic [CW-1:0]          cnt_q [NB];
   logic [CW-1:0]          cnt_d [NB];
   // Owner per player: {valid, button index}.
   logic [2:0]             own_q [NUM_PLAYERS];
   logic [2:0]             own_d [NUM_PLAYERS];
   logic [ND-1:0]          direct_q, direct_d;
   logic [NUM_PLAYERS-1:0] moving_q, moving_d;
`ifdef DIRECT_TURN_PULSE_EN
   logic [NUM_PLAYERS-1:0] turn_q, turn_d;
`endif

   // Index of the highest-priority set bit (L > R > U > D).
   function automatic logic [1:0] first_set(input logic [3:0] v);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (v[i]) r = 2'(i);
      end
      return r;
   endfunction

   // A newly risen button takes ownership. If the owner is released, the
   // highest-priority button still held becomes the owner.
   function automatic logic [2:0] next_owner(input logic [3:0] nxt,
                                             input logic [3:0] cur,
                                             input logic [2:0] own);
      logic [3:0] rise;
      rise = nxt & ~cur;
      if (rise != 4'd0)           return {1'b1, first_set(rise)};
      if (own[2] && nxt[own[1:0]]) return own;
      if (nxt != 4'd0)            return {1'b1, first_set(nxt)};
      return 3'b000;
   endfunction

   // Returns {moving, heading} for one player's stable buttons.
   function automatic logic [3:0] decode(input logic [3:0] d,
                                         input logic [2:0] own,
                                         input logic [2:0] cur);
      if ($onehot(d))                         return {1'b1, 1'b0, first_set(d)};
      if ((d != 4'd0) && (MULTI_MODE != 0))   return {1'b1, 1'b0, own[1:0]};
      return {1'b0, cur};
   endfunction

   // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive mismatches.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < NB; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == TERM) stable_d[i] = sync2_q[i];
            else                  cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end

   // Owner tracking moves with the stable bits so both stay aligned.
   always_comb begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         own_d[p] = next_owner(stable_d[4*p +: 4], stable_q[4*p +: 4], own_q[p]);
      end
   end

   // Decode stage: heading and moving flag per player.
   always_comb begin
      direct_d = direct_q;
      moving_d = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         {moving_d[p], direct_d[3*p +: 3]} =
            decode(stable_q[4*p +: 4], own_q[p], direct_q[3*p +: 3]);
      end
   end

`ifdef DIRECT_TURN_PULSE_EN
   // Pulse only when the heading value actually changes.
   always_comb begin
      turn_d = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         turn_d[p] = (direct_d[3*p +: 3] != direct_q[3*p +: 3]);
      end
   end
`endif

   // State registers.
   always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
         for (int p = 0; p < NUM_PLAYERS; p++) own_q[p] <= 3'b000;
         direct_q <= {NUM_PLAYERS{RESET_DIR}};
         moving_q <= '0;
`ifdef DIRECT_TURN_PULSE_EN
         turn_q   <= '0;
`endif
      end else begin
         sync1_q  <= btn;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
         for (int p = 0; p < NUM_PLAYERS; p++) own_q[p] <= own_d[p];
         direct_q <= direct_d;
         moving_q <= moving_d;
`ifdef DIRECT_TURN_PULSE_EN
         turn_q   <= turn_d;
`endif
      end
   end

   assign direct = direct_q;
   assign moving = moving_q;
`ifdef DIRECT_TURN_PULSE_EN
   assign turn   = turn_q;
`endif

endmodule

// File: tb/tb_direct_ctrl_multi.sv
// -----------------------------------------------------------------------------
// tb_direct_ctrl_multi
// Bench for direct_ctrl_multi. It runs two instances, one with MULTI_MODE 0
// and one with MULTI_MODE 1, both fed from the same buttons. A reference model
// predicts each output every cycle, and a few literal checks pin down the
// model itself.
// -----------------------------------------------------------------------------
module tb_direct_ctrl_multi;

   localparam int unsigned NP  = 2;
   localparam int unsigned DEB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] btn = 8'h00;
   logic [5:0] dir0, dir1;
   logic [1:0] mov0, mov1;
`ifdef DIRECT_TURN_PULSE_EN
   logic [1:0] turn0, turn1;
`endif

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   direct_ctrl_multi #(.NUM_PLAYERS(NP), .DEBOUNCE_CYCLES(DEB), .MULTI_MODE(0), .RESET_DIR(3'b010)) dut0 (
      .clk_100mhz(clk), .rst(rst), .btn(btn), .direct(dir0), .moving(mov0)
`ifdef DIRECT_TURN_PULSE_EN
      , .turn(turn0)
`endif
   );

   direct_ctrl_multi #(.NUM_PLAYERS(NP), .DEBOUNCE_CYCLES(DEB), .MULTI_MODE(1), .RESET_DIR(3'b010)) dut1 (
      .clk_100mhz(clk), .rst(rst), .btn(btn), .direct(dir1), .moving(mov1)
`ifdef DIRECT_TURN_PULSE_EN
      , .turn(turn1)
`endif
   );

   task automatic check(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- reference model ----------------
   logic [7:0]     p1, p2;          // synchroniser pipeline
   logic [7:0]     mst;             // accepted button levels
   logic [DEB-1:0] win [8];         // last DEB synchronised samples per bit
   int             owner [2];       // -1 = none
   int             mdir [2][2];     // [mode][player]
   int             mmov [2][2];
   int             mturn [2][2];

   function automatic int lowest(input logic [3:0] v);
      int r;
      r = -1;
      for (int i = 3; i >= 0; i--) if (v[i]) r = i;
      return r;
   endfunction

   task automatic model_reset();
      p1 = '0; p2 = '0; mst = '0;
      for (int b = 0; b < 8; b++) win[b] = '0;
      for (int p = 0; p < 2; p++) begin
         owner[p] = -1;
         for (int m = 0; m < 2; m++) begin
            mdir[m][p] = 2; mmov[m][p] = 0; mturn[m][p] = 0;
         end
      end
   endtask

   task automatic model_step();
      logic [7:0] nst;
      logic [3:0] d, nd, rise;
      int         od;
      // output register sees the levels accepted before this edge
      for (int m = 0; m < 2; m++) begin
         for (int p = 0; p < 2; p++) begin
            d  = mst[4*p +: 4];
            od = mdir[m][p];
            if ($countones(d) == 1) begin
               mdir[m][p] = lowest(d); mmov[m][p] = 1;
            end else if ($countones(d) > 1 && m == 1) begin
               mdir[m][p] = owner[p];  mmov[m][p] = 1;
            end else begin
               mmov[m][p] = 0;
            end
            mturn[m][p] = (mdir[m][p] != od) ? 1 : 0;
         end
      end
      // a level is accepted once the last DEB samples all disagree with it
      nst = mst;
      for (int b = 0; b < 8; b++) begin
         win[b] = {win[b][DEB-2:0], p2[b]};
         if (win[b] == {DEB{~mst[b]}}) nst[b] = p2[b];
      end
      for (int p = 0; p < 2; p++) begin
         nd   = nst[4*p +: 4];
         rise = nd & ~mst[4*p +: 4];
         if (rise != 4'd0)                   owner[p] = lowest(rise);
         else if (owner[p] >= 0 && nd[owner[p]]) owner[p] = owner[p];
         else if (nd != 4'd0)                owner[p] = lowest(nd);
         else                                owner[p] = -1;
      end
      mst = nst;
      p2  = p1;
      p1  = btn;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else     model_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            for (int p = 0; p < 2; p++) begin
               check("m0_direct", int'(dir0[3*p +: 3]), mdir[0][p]);
               check("m0_moving", int'(mov0[p]),        mmov[0][p]);
               check("m1_direct", int'(dir1[3*p +: 3]), mdir[1][p]);
               check("m1_moving", int'(mov1[p]),        mmov[1][p]);
`ifdef DIRECT_TURN_PULSE_EN
               check("m0_turn",   int'(turn0[p]),       mturn[0][p]);
               check("m1_turn",   int'(turn1[p]),       mturn[1][p]);
`endif
            end
         end
      end
   end

   // ---------------- directed + random stimulus ----------------
   initial begin
      int hold;
      btn = 8'h00;
      rst = 1'b1;
      cyc(3);
      check("rst_dir0", int'(dir0), 6'b010010);
      check("rst_mov0", int'(mov0), 0);
      check("rst_dir1", int'(dir1), 6'b010010);
      check("rst_mov1", int'(mov1), 0);
`ifdef DIRECT_TURN_PULSE_EN
      check("rst_turn0", int'(turn0), 0);
`endif
      rst = 1'b0;
      cyc(2);

      // P0 LEFT: output appears on the 7th edge after the first sample
      btn = 8'h01;
      cyc(6);
      check("l_lat_early", int'(mov0[0]), 0);
      cyc(1);
      check("l_lat_mov", int'(mov0[0]), 1);
      check("l_lat_dir", int'(dir0[2:0]), 0);
      check("l_lat_dir1", int'(dir1[2:0]), 0);
`ifdef DIRECT_TURN_PULSE_EN
      check("turn_pulse", int'(turn0[0]), 1);
      check("turn_p1_quiet", int'(turn0[1]), 0);
      cyc(1);
      check("turn_end", int'(turn0[0]), 0);
`endif
      btn = 8'h00;
      cyc(10);
      check("l_rel_mov", int'(mov0[0]), 0);
      check("l_rel_dir", int'(dir0[2:0]), 0);
`ifdef DIRECT_TURN_PULSE_EN
      btn = 8'h01;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         check("repress_noturn", int'(turn0[0]), 0);
      end
      btn = 8'h00;
      cyc(10);
`endif

      // short UP glitch is ignored, long pulse is accepted
      btn = 8'h04;
      cyc(3);
      btn = 8'h00;
      cyc(12);
      check("glitch_dir", int'(dir0[2:0]), 0);
      check("glitch_mov", int'(mov0[0]), 0);
      btn = 8'h04;
      cyc(10);
      check("up_dir", int'(dir0[2:0]), 2);
      check("up_mov", int'(mov0[0]), 1);
      btn = 8'h00;
      cyc(10);
      check("up_rel_dir", int'(dir0[2:0]), 2);
      check("up_rel_mov", int'(mov0[0]), 0);

      // P1 RIGHT, then RIGHT+DOWN
      btn = 8'h20;
      cyc(10);
      check("r_dir_m0", int'(dir0[5:3]), 1);
      check("r_mov_m0", int'(mov0[1]), 1);
      check("r_dir_m1", int'(dir1[5:3]), 1);
      btn = 8'hA0;
      cyc(10);
      check("rd_mov_m0", int'(mov0[1]), 0);
      check("rd_dir_m0", int'(dir0[5:3]), 1);
      check("rd_dir_m1", int'(dir1[5:3]), 3);
      check("rd_mov_m1", int'(mov1[1]), 1);
      btn = 8'h20;
      cyc(10);
      check("d_rel_dir_m1", int'(dir1[5:3]), 1);
      check("d_rel_mov_m1", int'(mov1[1]), 1);
      btn = 8'h00;
      cyc(10);
      btn = 8'h50;
      cyc(10);
      check("lu_dir_m1", int'(dir1[5:3]), 0);
      check("lu_mov_m1", int'(mov1[1]), 1);
      check("lu_mov_m0", int'(mov0[1]), 0);
      check("lu_dir_m0", int'(dir0[5:3]), 1);
      btn = 8'h00;
      cyc(10);

      // async reset mid-cycle while P0 is moving, then re-qualify the held button
      btn = 8'h01;
      cyc(10);
      #2 rst = 1'b1;
      #1;
      check("arst_dir0", int'(dir0), 6'b010010);
      check("arst_mov0", int'(mov0), 0);
      check("arst_dir1", int'(dir1), 6'b010010);
      @(negedge clk);
      rst = 1'b0;
      cyc(6);
      check("requal_early", int'(mov0[0]), 0);
      cyc(1);
      check("requal_mov", int'(mov0[0]), 1);
      check("requal_dir", int'(dir0[2:0]), 0);

      // random phase
      for (int s = 0; s < 300; s++) begin
         btn  = 8'($urandom);
         hold = int'($urandom_range(1, 12));
         cyc(hold);
         if (s == 150) begin
            #($urandom_range(1, 4)) rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
      end
      btn = 8'h00;
      cyc(12);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
